// File: rtl/rv32i_pkg.sv
// RV32I constants shared by the encoder and the datapath decode logic.
// Holds the OP opcode, funct3/funct7 values and the ALUControl codes.
package rv32i_pkg;

  localparam logic [6:0] OPCODE_OP = 7'b0110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef logic [2:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_ADD = 3'b000;
  localparam alu_ctrl_t ALU_SUB = 3'b001;
  localparam alu_ctrl_t ALU_SLT = 3'b101;
  localparam alu_ctrl_t ALU_OR  = 3'b011;
  localparam alu_ctrl_t ALU_AND = 3'b010;

endpackage

// File: rtl/rtype_instr_encoder_if.sv
// Request and instruction-stream bundle of the R-type encoder.
// master drives requests / consumes words; slave is the encoder.
interface rtype_instr_encoder_if #(
  parameter int DEPTH = 4
) ();
  import rv32i_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic          req_valid;
  logic          req_ready;
  alu_ctrl_t     alu_ctrl;
  logic [4:0]    rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [31:0]   instr_addr;
  logic          err_illegal;
  logic [CW-1:0] count;

  modport master (
    output req_valid, alu_ctrl, rd, rs1, rs2, instr_ready,
    input  req_ready, instr_valid, instr, instr_addr,
    input  err_illegal, count
  );

  modport slave (
    input  req_valid, alu_ctrl, rd, rs1, rs2, instr_ready,
    output req_ready, instr_valid, instr, instr_addr,
    output err_illegal, count
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-2 depth, registered occupancy count.
// Ports: clk, rst, push/wdata, pop/rdata, full, empty, count.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_ptr_q];
  // Push is blocked when full even if a pop happens: no bypass.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/rtype_instr_encoder.sv
// Encodes ALUControl requests into RV32I R-type words and streams them.
// Ports: clk, rst, bus (slave: req/instr handshakes, err_illegal, count).
module rtype_instr_encoder
  import rv32i_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic                  clk,
  input logic                  rst,
  rtype_instr_encoder_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Returns {legal, word}.
  function automatic logic [32:0] encode(
    input alu_ctrl_t  op,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2
  );
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ok;
    f3 = F3_ADD_SUB;
    f7 = F7_BASE;
    ok = 1'b1;
    unique case (op)
      ALU_ADD: f3 = F3_ADD_SUB;
      ALU_SUB: f7 = F7_ALT;
      ALU_SLT: f3 = F3_SLT;
      ALU_OR:  f3 = F3_OR;
      ALU_AND: f3 = F3_AND;
      default: ok = 1'b0;
    endcase
    return {ok, f7, rs2, rs1, f3, rd, OPCODE_OP};
  endfunction

  logic [32:0]   enc;
  logic          legal;
  logic          accept;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] fifo_count;
  logic          err_q, err_d;
  logic [31:0]   addr_q, addr_d;

  assign enc    = encode(bus.alu_ctrl, bus.rd, bus.rs1, bus.rs2);
  assign legal  = enc[32];
  assign accept = bus.req_valid && bus.req_ready;
  assign push   = accept && legal;
  assign pop    = bus.instr_valid && bus.instr_ready;

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .wdata(enc[31:0]),
    .rdata(bus.instr),
    .full (full),
    .empty(empty),
    .count(fifo_count)
  );

  assign bus.req_ready   = !full;
  assign bus.instr_valid = !empty;
  assign bus.count       = fifo_count;
  assign bus.instr_addr  = addr_q;
  assign bus.err_illegal = err_q;

  always_comb begin
    err_d  = accept && !legal;
    addr_d = addr_q;
    if (pop) addr_d = addr_q + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= 1'b0;
      addr_q <= BASE_ADDR;
    end else begin
      err_q  <= err_d;
      addr_q <= addr_d;
    end
  end

endmodule
